// File: rtl/ws2812_pkg.sv
// Shared types and constants for the ws2812 LED driver front end.
//   RGB_W     : width of one GRB pixel word as shifted by the driver
//   LED_IDX_W : width of an LED index on the driver write port
//   state_t   : write-controller sequencing states
//   req_t     : one pixel-write request {valid, led, rgb}
package ws2812_pkg;

  localparam int RGB_W     = 24;
  localparam int LED_IDX_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [LED_IDX_W-1:0] led;
    logic [RGB_W-1:0]     rgb;
  } req_t;

endpackage

// File: rtl/ws2812_write_ctrl_if.sv
// Bus bundle between the pixel-write clients and ws2812_write_ctrl.
//   req0_* / req1_* : two valid/ready pixel-write requesters
//   fill_*          : fill-sequence control and status
//   range_err       : sticky out-of-range index flag
//   drv_*           : write port toward the ws2812 driver
// Modports:
//   master : client side (drives requests and fill control)
//   slave  : controller side (drives readies, status and driver port)
interface ws2812_write_ctrl_if;
  import ws2812_pkg::*;

  logic                 req0_valid;
  logic                 req0_ready;
  logic [LED_IDX_W-1:0] req0_led;
  logic [RGB_W-1:0]     req0_rgb;

  logic                 req1_valid;
  logic                 req1_ready;
  logic [LED_IDX_W-1:0] req1_led;
  logic [RGB_W-1:0]     req1_rgb;

  logic                 fill_start;
  logic [RGB_W-1:0]     fill_rgb;
  logic                 fill_busy;
  logic                 fill_done;
  logic                 range_err;

  logic                 drv_write;
  logic [LED_IDX_W-1:0] drv_led_num;
  logic [RGB_W-1:0]     drv_rgb_data;

  modport master (
    output req0_valid, req0_led, req0_rgb,
    output req1_valid, req1_led, req1_rgb,
    output fill_start, fill_rgb,
    input  req0_ready, req1_ready,
    input  fill_busy, fill_done, range_err,
    input  drv_write, drv_led_num, drv_rgb_data
  );

  modport slave (
    input  req0_valid, req0_led, req0_rgb,
    input  req1_valid, req1_led, req1_rgb,
    input  fill_start, fill_rgb,
    output req0_ready, req1_ready,
    output fill_busy, fill_done, range_err,
    output drv_write, drv_led_num, drv_rgb_data
  );

endinterface

// File: rtl/ws2812_write_ctrl_rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : request lines
//   enable     : when low no grant is issued and history is unchanged
//   gnt[1:0]   : one-hot grant, or zero
// On contention the requester not granted most recently wins; after reset
// requester 0 wins the first contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic last_grant;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case/if can leave it unassigned and infer a latch.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (gnt[0]) begin
      last_grant <= 1'b0;
    end else if (gnt[1]) begin
      last_grant <= 1'b1;
    end
  end

endmodule

// File: rtl/ws2812_write_ctrl.sv
// Write-port controller for the ws2812 LED driver.
//   clk, reset : clock, synchronous active-high reset
//   bus        : ws2812_write_ctrl_if.slave
//                - two requesters arbitrated round-robin (ready is
//                  combinational, a grant completes the transfer)
//                - fill sequence writing one colour to every LED
//                - sticky range_err for accepted out-of-range indices
//                - registered drv_* port toward the driver
// Parameter NUM_LEDS: LEDs on the chain, valid indices 0..NUM_LEDS-1.
module ws2812_write_ctrl
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8
) (
  input logic               clk,
  input logic               reset,
  ws2812_write_ctrl_if.slave bus
);

  // One extra bit so a power-of-two chain length cannot wrap the counter.
  localparam int              IDX_W    = $clog2(NUM_LEDS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

  state_t               state, state_next;
  logic [IDX_W-1:0]     fill_idx, fill_idx_next, idx_inc;
  logic [RGB_W-1:0]     fill_rgb_q, fill_rgb_next;
  logic                 drv_write_q, drv_write_next;
  logic [LED_IDX_W-1:0] drv_led_q, drv_led_next;
  logic [RGB_W-1:0]     drv_rgb_q, drv_rgb_next;
  logic                 range_err_q, range_err_next;

  req_t                 r0, r1, sel;
  logic [1:0]           gnt;
  logic                 arb_enable;
  logic                 sel_in_range;

  assign r0 = '{valid: bus.req0_valid, led: bus.req0_led, rgb: bus.req0_rgb};
  assign r1 = '{valid: bus.req1_valid, led: bus.req1_led, rgb: bus.req1_rgb};

  // Fill has priority over requesters; readies are also forced low while
  // reset is asserted so nothing is consumed that will not be written.
  assign arb_enable = !reset && (state == ST_IDLE) && !bus.fill_start;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({r1.valid, r0.valid}),
    .enable (arb_enable),
    .gnt    (gnt)
  );

  assign sel          = gnt[1] ? r1 : r0;
  assign sel_in_range = (int'(sel.led) < NUM_LEDS);
  assign idx_inc      = fill_idx + 1'b1;

  // fill_idx holds the index currently presented on the driver port while
  // in FILL, so the final write and fill_done line up in the same cycle.
  always_comb begin
    state_next     = state;
    fill_idx_next  = fill_idx;
    fill_rgb_next  = fill_rgb_q;
    drv_write_next = 1'b0;
    drv_led_next   = drv_led_q;
    drv_rgb_next   = drv_rgb_q;
    range_err_next = range_err_q;

    case (state)
      ST_IDLE: begin
        if (bus.fill_start) begin
          state_next     = ST_FILL;
          fill_rgb_next  = bus.fill_rgb;
          fill_idx_next  = '0;
          drv_write_next = 1'b1;
          drv_led_next   = '0;
          drv_rgb_next   = bus.fill_rgb;
        end else if (sel.valid && (gnt != 2'b00)) begin
          if (sel_in_range) begin
            drv_write_next = 1'b1;
            drv_led_next   = sel.led;
            drv_rgb_next   = sel.rgb;
          end else begin
            range_err_next = 1'b1;
          end
        end
      end

      ST_FILL: begin
        if (fill_idx == LAST_IDX) begin
          state_next = ST_IDLE;
        end else begin
          fill_idx_next  = idx_inc;
          drv_write_next = 1'b1;
          drv_led_next   = LED_IDX_W'(idx_inc);
          drv_rgb_next   = fill_rgb_q;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      fill_idx    <= '0;
      fill_rgb_q  <= '0;
      drv_write_q <= 1'b0;
      drv_led_q   <= '0;
      drv_rgb_q   <= '0;
      range_err_q <= 1'b0;
    end else begin
      state       <= state_next;
      fill_idx    <= fill_idx_next;
      fill_rgb_q  <= fill_rgb_next;
      drv_write_q <= drv_write_next;
      drv_led_q   <= drv_led_next;
      drv_rgb_q   <= drv_rgb_next;
      range_err_q <= range_err_next;
    end
  end

  assign bus.req0_ready   = gnt[0];
  assign bus.req1_ready   = gnt[1];
  assign bus.fill_busy    = (state == ST_FILL);
  assign bus.fill_done    = (state == ST_FILL) && (fill_idx == LAST_IDX);
  assign bus.range_err    = range_err_q;
  assign bus.drv_write    = drv_write_q;
  assign bus.drv_led_num  = drv_led_q;
  assign bus.drv_rgb_data = drv_rgb_q;

endmodule

// File: tb/tb_ws2812_write_ctrl.sv
// Directed self-checking bench for ws2812_write_ctrl (NUM_LEDS = 8).
// Inputs are driven and outputs sampled 1 time unit after the falling edge.
module tb_ws2812_write_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  ws2812_write_ctrl_if bus ();

  ws2812_write_ctrl #(.NUM_LEDS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_led = 8'd0; bus.req0_rgb = 24'd0;
    bus.req1_valid = 1'b0; bus.req1_led = 8'd0; bus.req1_rgb = 24'd0;
    bus.fill_start = 1'b0; bus.fill_rgb = 24'd0;
  endtask

  task automatic test_reset();
    logic [36:0] obs;
    idle_inputs();
    reset = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    tests_run++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_readies: got %b exp 00", {bus.req1_ready, bus.req0_ready});
    end
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    obs = {bus.drv_write, bus.drv_led_num, bus.drv_rgb_data, bus.fill_busy,
           bus.fill_done, bus.range_err, bus.req0_ready, bus.req1_ready};
    tests_run++;
    if (obs !== 37'd0) begin
      tests_failed++;
      $display("FAIL reset_values: got %h exp 0", obs);
    end
  endtask

  // Both requesters valid for 8 cycles: grants 0,1,0,1,... and one write per cycle.
  task automatic test_contention();
    int n0 = 0;
    int n1 = 0;
    logic [7:0]  exp_led = 8'd0;
    logic [23:0] exp_rgb = 24'd0;
    logic        have_exp = 1'b0;
    logic [1:0]  exp_gnt;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_led = 8'(n0);     bus.req0_rgb = 24'(24'h100000 + n0);
      bus.req1_valid = 1'b1; bus.req1_led = 8'(4 + n1); bus.req1_rgb = 24'(24'h200000 + n1);
      #1;
      if (have_exp) begin
        tests_run++;
        if ({bus.drv_write, bus.drv_led_num, bus.drv_rgb_data} !== {1'b1, exp_led, exp_rgb}) begin
          tests_failed++;
          $display("FAIL contention_write[%0d]: got w=%0b led=%0d rgb=%h exp w=1 led=%0d rgb=%h",
                   k, bus.drv_write, bus.drv_led_num, bus.drv_rgb_data, exp_led, exp_rgb);
        end
      end
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      tests_run++;
      if ({bus.req1_ready, bus.req0_ready} !== exp_gnt) begin
        tests_failed++;
        $display("FAIL contention_grant[%0d]: got %b exp %b", k, {bus.req1_ready, bus.req0_ready}, exp_gnt);
      end
      if (k % 2 == 0) begin
        exp_led = 8'(n0); exp_rgb = 24'(24'h100000 + n0); n0++;
      end else begin
        exp_led = 8'(4 + n1); exp_rgb = 24'(24'h200000 + n1); n1++;
      end
      have_exp = 1'b1;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    tests_run++;
    if ({bus.drv_write, bus.drv_led_num, bus.drv_rgb_data} !== {1'b1, exp_led, exp_rgb}) begin
      tests_failed++;
      $display("FAIL contention_last_write: got w=%0b led=%0d exp w=1 led=%0d",
               bus.drv_write, bus.drv_led_num, exp_led);
    end
    @(negedge clk); #1;
    tests_run++;
    if (bus.drv_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL contention_idle: got drv_write=%0b exp 0", bus.drv_write);
    end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_led = 8'd3; bus.req0_rgb = 24'h00FF00;
    #1;
    tests_run++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_ready: got %b exp 01", {bus.req1_ready, bus.req0_ready});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    tests_run++;
    if ({bus.drv_write, bus.drv_led_num, bus.drv_rgb_data} !== {1'b1, 8'd3, 24'h00FF00}) begin
      tests_failed++;
      $display("FAIL single_write: got w=%0b led=%0d rgb=%h exp w=1 led=3 rgb=00ff00",
               bus.drv_write, bus.drv_led_num, bus.drv_rgb_data);
    end
  endtask

  // Fill with req1 pending throughout; a mid-fill fill_start must be ignored.
  task automatic test_fill();
    @(negedge clk);
    bus.fill_start = 1'b1; bus.fill_rgb = 24'h0000FF;
    bus.req1_valid = 1'b1; bus.req1_led = 8'd2; bus.req1_rgb = 24'hABCDEF;
    #1;
    tests_run++;
    if ({bus.fill_busy, bus.req1_ready, bus.req0_ready} !== 3'b000) begin
      tests_failed++;
      $display("FAIL fill_start_cycle: got busy/r1/r0=%b exp 000",
               {bus.fill_busy, bus.req1_ready, bus.req0_ready});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.fill_start = (i == 2);
      bus.fill_rgb   = (i == 2) ? 24'hFFFFFF : 24'h0000FF;
      #1;
      tests_run++;
      if ({bus.fill_busy, bus.drv_write, bus.drv_led_num, bus.drv_rgb_data,
           bus.fill_done, bus.req1_ready, bus.req0_ready}
          !== {1'b1, 1'b1, 8'(i), 24'h0000FF, (i == 7), 2'b00}) begin
        tests_failed++;
        $display("FAIL fill_write[%0d]: got busy=%0b w=%0b led=%0d rgb=%h done=%0b rdy=%b exp busy=1 w=1 led=%0d rgb=0000ff done=%0b rdy=00",
                 i, bus.fill_busy, bus.drv_write, bus.drv_led_num, bus.drv_rgb_data,
                 bus.fill_done, {bus.req1_ready, bus.req0_ready}, i, (i == 7));
      end
    end
    @(negedge clk);
    bus.fill_start = 1'b0;
    #1;
    tests_run++;
    if ({bus.fill_busy, bus.fill_done, bus.drv_write, bus.req1_ready, bus.req0_ready} !== 5'b00010) begin
      tests_failed++;
      $display("FAIL fill_after: got busy/done/w/r1/r0=%b exp 00010",
               {bus.fill_busy, bus.fill_done, bus.drv_write, bus.req1_ready, bus.req0_ready});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    tests_run++;
    if ({bus.drv_write, bus.drv_led_num, bus.drv_rgb_data} !== {1'b1, 8'd2, 24'hABCDEF}) begin
      tests_failed++;
      $display("FAIL fill_req1_write: got w=%0b led=%0d rgb=%h exp w=1 led=2 rgb=abcdef",
               bus.drv_write, bus.drv_led_num, bus.drv_rgb_data);
    end
  endtask

  task automatic test_fill_vs_req();
    int writes = 0;
    int early  = 0;
    @(negedge clk);
    bus.fill_start = 1'b1; bus.fill_rgb = 24'h123456;
    bus.req0_valid = 1'b1; bus.req0_led = 8'd5; bus.req0_rgb = 24'h654321;
    #1;
    tests_run++;
    if (bus.req0_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_beats_req: got req0_ready=%0b exp 0", bus.req0_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.fill_start = 1'b0;
      #1;
      if (bus.drv_write === 1'b1) writes++;
      if (bus.req0_ready !== 1'b0) early++;
    end
    tests_run++;
    if ({writes, early} !== {32'd8, 32'd0}) begin
      tests_failed++;
      $display("FAIL fill_vs_req_fill: got writes=%0d early_ready=%0d exp writes=8 early_ready=0", writes, early);
    end
    @(negedge clk); #1;
    tests_run++;
    if (bus.req0_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_vs_req_served: got req0_ready=%0b exp 1", bus.req0_ready);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    tests_run++;
    if ({bus.drv_write, bus.drv_led_num, bus.drv_rgb_data} !== {1'b1, 8'd5, 24'h654321}) begin
      tests_failed++;
      $display("FAIL fill_vs_req_write: got w=%0b led=%0d rgb=%h exp w=1 led=5 rgb=654321",
               bus.drv_write, bus.drv_led_num, bus.drv_rgb_data);
    end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    bus.req1_valid = 1'b1; bus.req1_led = 8'd8; bus.req1_rgb = 24'h111111;
    #1;
    tests_run++;
    if ({bus.req1_ready, bus.range_err} !== 2'b10) begin
      tests_failed++;
      $display("FAIL range_accept: got ready/err=%b exp 10", {bus.req1_ready, bus.range_err});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    tests_run++;
    if ({bus.drv_write, bus.range_err} !== 2'b01) begin
      tests_failed++;
      $display("FAIL range_no_write: got w/err=%b exp 01", {bus.drv_write, bus.range_err});
    end
    // Highest valid index still writes; the error flag stays set.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_led = 8'd7; bus.req0_rgb = 24'h0F0F0F;
    #1;
    tests_run++;
    if (bus.req0_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL range_max_ready: got %0b exp 1", bus.req0_ready);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    tests_run++;
    if ({bus.drv_write, bus.drv_led_num, bus.range_err} !== {1'b1, 8'd7, 1'b1}) begin
      tests_failed++;
      $display("FAIL range_max_write: got w=%0b led=%0d err=%0b exp w=1 led=7 err=1",
               bus.drv_write, bus.drv_led_num, bus.range_err);
    end
  endtask

  task automatic test_reset_in_fill();
    logic [36:0] obs;
    int stray = 0;
    @(negedge clk);
    bus.fill_start = 1'b1; bus.fill_rgb = 24'h00AA00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.fill_start = 1'b0;
      #1;
      tests_run++;
      if ({bus.drv_write, bus.drv_led_num} !== {1'b1, 8'(i)}) begin
        tests_failed++;
        $display("FAIL rif_write[%0d]: got w=%0b led=%0d exp w=1 led=%0d",
                 i, bus.drv_write, bus.drv_led_num, i);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    obs = {bus.drv_write, bus.drv_led_num, bus.drv_rgb_data, bus.fill_busy,
           bus.fill_done, bus.range_err, bus.req0_ready, bus.req1_ready};
    tests_run++;
    if (obs !== 37'd0) begin
      tests_failed++;
      $display("FAIL rif_reset_values: got %h exp 0", obs);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus.drv_write !== 1'b0 || bus.fill_done !== 1'b0 || bus.fill_busy !== 1'b0) stray++;
    end
    tests_run++;
    if (stray !== 0) begin
      tests_failed++;
      $display("FAIL rif_aborted: got %0d active cycles exp 0", stray);
    end
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_led = 8'd6; bus.req0_rgb = 24'h0A0B0C;
    #1;
    tests_run++;
    if (bus.req0_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rif_req_ready: got %0b exp 1", bus.req0_ready);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    tests_run++;
    if ({bus.drv_write, bus.drv_led_num, bus.drv_rgb_data} !== {1'b1, 8'd6, 24'h0A0B0C}) begin
      tests_failed++;
      $display("FAIL rif_req_write: got w=%0b led=%0d rgb=%h exp w=1 led=6 rgb=0a0b0c",
               bus.drv_write, bus.drv_led_num, bus.drv_rgb_data);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_write();
    test_fill();
    test_fill_vs_req();
    test_out_of_range();
    test_reset_in_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
